// File: rtl/adam_block_dma.sv
// adam_block_dma
// Copies one AdamNet disk block (SECS_PER_BLK sectors of 512 bytes) from the
// track loader's sector buffer into CPU RAM through RAM port B. Each sector
// is requested from the loader, then read one byte at a time and written to
// RAM with a write/acknowledge handshake.

module adam_block_dma #(
  parameter int          SECS_PER_BLK = 2,
  parameter int          BUF_LAT      = 1,
  parameter logic [23:0] LOAD_TMO     = 24'hFFFFFF
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic [31:0] block_i,
  input  logic [15:0] dest_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [31:0] disk_sector_o,
  output logic        disk_load_o,
  input  logic        disk_sector_loaded_i,
  input  logic        disk_error_i,
  output logic [8:0]  disk_addr_o,
  output logic        disk_wr_o,
  input  logic [7:0]  disk_data_i,
  output logic [15:0] ramb_addr_o,
  output logic        ramb_wr_o,
  output logic        ramb_rd_o,
  output logic [7:0]  ramb_dout_o,
  input  logic        ramb_wr_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_LOAD,
    S_ADDR,
    S_CAPT,
    S_WR,
    S_ACK,
    S_DONE
  } state_t;

  localparam int SEC_SHIFT = $clog2(SECS_PER_BLK);

  state_t      state;
  logic [31:0] block_q;
  logic [15:0] dest_q;
  logic [1:0]  sec_idx;
  logic [8:0]  byte_idx;
  logic [23:0] timer;
  logic [1:0]  lat_cnt;
  logic [31:0] sector_base;

  // This DMA only ever reads the sector buffer and only ever writes RAM.
  assign disk_wr_o = 1'b0;
  assign ramb_rd_o = 1'b0;

  // First sector of the block; three sectors per block is the only
  // non-power-of-two case and needs a real multiply.
  if (SECS_PER_BLK == 3) begin : g_mul
    assign sector_base = block_q * 32'd3;
  end else begin : g_shift
    assign sector_base = block_q << SEC_SHIFT;
  end

  // Transfer sequencer: sector request, per-byte read/capture/write/ack loop.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= S_IDLE;
      block_q       <= '0;
      dest_q        <= '0;
      sec_idx       <= '0;
      byte_idx      <= '0;
      timer         <= '0;
      lat_cnt       <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      error_o       <= 1'b0;
      disk_sector_o <= '0;
      disk_load_o   <= 1'b0;
      disk_addr_o   <= '0;
      ramb_addr_o   <= '0;
      ramb_wr_o     <= 1'b0;
      ramb_dout_o   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            block_q <= block_i;
            dest_q  <= dest_i;
            sec_idx <= '0;
            busy_o  <= 1'b1;
            state   <= S_REQ;
          end
        end

        S_REQ: begin
          disk_sector_o <= sector_base + {30'd0, sec_idx};
          disk_load_o   <= 1'b1;
          timer         <= '0;
          state         <= S_WAIT_LOAD;
        end

        // timer counts WAIT_LOAD cycles already spent; an error beats a
        // simultaneous loaded indication.
        S_WAIT_LOAD: begin
          if (disk_error_i) begin
            disk_load_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            error_o     <= 1'b1;
            state       <= S_DONE;
          end else if (disk_sector_loaded_i) begin
            disk_load_o <= 1'b0;
            byte_idx    <= '0;
            disk_addr_o <= '0;
            lat_cnt     <= '0;
            state       <= S_ADDR;
          end else if (timer == LOAD_TMO - 24'd1) begin
            disk_load_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            error_o     <= 1'b1;
            state       <= S_DONE;
          end else begin
            timer <= timer + 24'd1;
          end
        end

        S_ADDR: begin
          if (lat_cnt == 2'(BUF_LAT - 1)) begin
            state <= S_CAPT;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        // Capture the buffer byte and present address and data together so
        // both stay stable through the acknowledge wait.
        S_CAPT: begin
          ramb_dout_o <= disk_data_i;
          ramb_addr_o <= dest_q + {5'd0, sec_idx, byte_idx};
          ramb_wr_o   <= 1'b1;
          state       <= S_WR;
        end

        S_WR: begin
          ramb_wr_o <= 1'b0;
          state     <= S_ACK;
        end

        S_ACK: begin
          if (ramb_wr_ack_i) begin
            if (byte_idx != 9'd511) begin
              byte_idx    <= byte_idx + 9'd1;
              disk_addr_o <= byte_idx + 9'd1;
              lat_cnt     <= '0;
              state       <= S_ADDR;
            end else if (sec_idx != 2'(SECS_PER_BLK - 1)) begin
              sec_idx <= sec_idx + 2'd1;
              state   <= S_REQ;
            end else begin
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              error_o <= 1'b0;
              state   <= S_DONE;
            end
          end
        end

        S_DONE: begin
          done_o  <= 1'b0;
          error_o <= 1'b0;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
